uart_rx_req_ack: RTL and testbench

UART receive front end running in the serial-side clock domain. Oversamples the rx line, deframes 8N1-style characters LSB-first, and hands each received word to the system-clock side over a 4-phase async req/ack handshake. It is the producer stage directly upstream of the async-to-sync control block: async_req/async_d/async_ack connect straight across.

---
 rtl/uart_rx_req_ack.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_req_ack.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_req_ack.sv
// UART 8N1-style receiver that hands each received word to the system side over a 4-phase req/ack handshake.
// Latency: start-bit fall to async_req rise = SYNC_STAGE + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles.
// Backpressure: none on rx; a good frame arriving while the handshake is busy is dropped and flagged with overrun.
//
// Ports:
//   clock, reset   serial-side clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   async_req/ack  4-phase handshake to the consumer (ack is asynchronous)
//   async_d        received word, stable while a request is in flight
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: good frame dropped because handshake was busy
//   busy           receiver FSM is not idle
module uart_rx_req_ack #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGE   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  async_req,
  input  logic                  async_ack,
  output logic [DATA_WIDTH-1:0] async_d,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------- synchronizers
  logic w_rx_s;
  logic w_ack_s;

  generate
    if (SYNC_STAGE == 0) begin : g_nosync
      assign w_rx_s  = rx;
      assign w_ack_s = async_ack;
    end else begin : g_sync
      logic [SYNC_STAGE-1:0] r_rx_sync;
      logic [SYNC_STAGE-1:0] r_ack_sync;
      // rx resets to the idle-high level so reset release never looks like a start bit
      always_ff @(posedge clock) begin
        if (reset) begin
          r_rx_sync  <= '1;
          r_ack_sync <= '0;
        end else begin
          r_rx_sync  <= (r_rx_sync << 1) | SYNC_STAGE'(rx);
          r_ack_sync <= (r_ack_sync << 1) | SYNC_STAGE'(async_ack);
        end
      end
      assign w_rx_s  = r_rx_sync[SYNC_STAGE-1];
      assign w_ack_s = r_ack_sync[SYNC_STAGE-1];
    end
  endgenerate

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;

  rx_state_t               r_state;
  rx_state_t               w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    w_half;
  logic                    w_bit_end;
  logic                    w_good;
  logic                    w_bad;
  logic                    w_cnt_clr;
  logic                    w_busy;

  assign w_half    = (r_cnt == HALF_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_state_nxt = S_START;
      S_START: if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_end && (r_idx == IDX_LAST)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_good    = (r_state == S_STOP) && w_bit_end && w_rx_s;
    w_bad     = (r_state == S_STOP) && w_bit_end && !w_rx_s;
    // cnt restarts on every state change and at each data-bit boundary
    w_cnt_clr = (w_state_nxt != r_state) || (r_state == S_IDLE) ||
                (r_state == S_BREAK) || ((r_state == S_DATA) && w_bit_end);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (r_state == S_START) begin
        r_idx <= '0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + IW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- handshake FSM
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} hs_state_t;

  hs_state_t             r_hs;
  hs_state_t             w_hs_nxt;
  logic                  w_load;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_frame_err;
  logic                  r_overrun;

  always_ff @(posedge clock) begin
    if (reset) r_hs <= H_IDLE;
    else       r_hs <= w_hs_nxt;
  end

  always_comb begin
    w_hs_nxt = r_hs;
    case (r_hs)
      H_IDLE:  if (w_load) w_hs_nxt = H_REQ;
      H_REQ:   if (w_ack_s) w_hs_nxt = H_REL;
      H_REL:   if (!w_ack_s) w_hs_nxt = H_IDLE;
      default: w_hs_nxt = H_IDLE;
    endcase
  end

  // A new request needs a fully idle handshake: ack must have been seen low again.
  always_comb begin
    w_load = (r_hs == H_IDLE) && w_good && !w_ack_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_d         <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_req       <= (w_hs_nxt == H_REQ);
      r_frame_err <= w_bad;
      r_overrun   <= w_good && !w_load;
      if (w_load) r_d <= r_shift;
    end
  end

  assign async_req = r_req;
  assign async_d   = r_d;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = w_busy;

endmodule

// File: tb/tb_uart_rx_req_ack.sv
// Testbench for uart_rx_req_ack: serial frame driver, 4-phase responder, and scoreboard of expected words.
// Latency: expected start-to-request latency derived from bit timing, checked on every request/error pulse.
// Backpressure: responder delays are randomized or held off to provoke overrun.
module tb_uart_rx_req_ack;

  localparam int DW   = 8;
  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + CPB / 2 + DW * CPB + CPB + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic          async_req;
  logic          async_ack;
  logic [DW-1:0] async_d;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_rx_req_ack #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .SYNC_STAGE(SYNC)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .async_req (async_req),
    .async_ack (async_ack),
    .async_d   (async_d),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------- reference model state
  logic [DW-1:0] exp_q[$];
  int            start_cyc     = 0;
  int            ack_rise_cyc  = 0;
  int            req_fall_cyc  = 0;
  int            n_req = 0, n_ferr = 0, n_ovr = 0;

  // Detection of the start edge may shift the result by one cycle either way.
  function automatic int lat_norm(input int l);
    return (l >= LAT - 1 && l <= LAT + 1) ? LAT : l;
  endfunction

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  // ---------------------------------------------------------------- responder
  logic ack_en = 1'b1;
  int   up_dly = 5;
  int   dn_dly = 3;

  initial begin
    async_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (ack_en && async_req && !async_ack) begin
        repeat (up_dly) @(posedge clock);
        #1;
        async_ack    = 1'b1;
        ack_rise_cyc = cyc;
        while (async_req) @(negedge clock);
        repeat (dn_dly) @(posedge clock);
        #1;
        async_ack = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  logic          prev_req = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
  logic [DW-1:0] held_d = '0;

  always @(negedge clock) begin
    if (async_req && !prev_req) begin
      n_req++;
      chk("req_latency", lat_norm(cyc - start_cyc), LAT);
      if (exp_q.size() == 0) chk("req_unexpected", 1, 0);
      else                   chk("req_data", async_d, exp_q.pop_front());
      held_d = async_d;
    end else if (async_req && prev_req) begin
      chk("d_stable", async_d, held_d);
    end
    if (!async_req && prev_req) req_fall_cyc = cyc;
    if (frame_err) begin
      chk("ferr_one_cycle", prev_ferr, 0);
      if (!prev_ferr) begin
        n_ferr++;
        chk("ferr_latency", lat_norm(cyc - start_cyc), LAT);
      end
    end
    if (overrun) begin
      chk("ovr_one_cycle", prev_ovr, 0);
      if (!prev_ovr) begin
        n_ovr++;
        chk("ovr_latency", lat_norm(cyc - start_cyc), LAT);
      end
    end
    if (frame_err || overrun) chk("err_exclusive", frame_err & overrun, 0);
    prev_req  = async_req;
    prev_ferr = frame_err;
    prev_ovr  = overrun;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  async_req, 0);
    chk({tag, "_d"},    async_d,   0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"},  overrun,   0);
    chk({tag, "_busy"}, busy,      0);
  endtask

  // ---------------------------------------------------------------- stimulus
  int r0, f0, o0;
  logic [DW-1:0] b;
  logic [DW-1:0] seq2 [3];

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    tick(4);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(4);

    // single frame, slow responder
    r0 = n_req; f0 = n_ferr; o0 = n_ovr;
    up_dly = 5; dn_dly = 3;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(30);
    chk("t1_req_count", n_req - r0, 1);
    chk("t1_req_fall",  req_fall_cyc - ack_rise_cyc, SYNC + 1);
    chk("t1_ferr",      n_ferr - f0, 0);
    chk("t1_ovr",       n_ovr - o0, 0);
    chk("t1_req_low",   async_req, 0);
    chk("t1_d_hold",    async_d, 8'hA5);

    // back-to-back frames, fast responder
    r0 = n_req; o0 = n_ovr;
    up_dly = 1; dn_dly = 1;
    seq2[0] = 8'h00; seq2[1] = 8'hFF; seq2[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq2[i]);
      send_frame(seq2[i], 1'b1);
    end
    tick(30);
    chk("t2_req_count", n_req - r0, 3);
    chk("t2_ovr",       n_ovr - o0, 0);
    chk("t2_queue",     exp_q.size(), 0);

    // false start
    r0 = n_req; f0 = n_ferr;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    @(negedge clock);
    chk("t3_busy_high", busy, 1);
    tick(12);
    chk("t3_busy_low",  busy, 0);
    chk("t3_no_req",    n_req - r0, 0);
    chk("t3_no_ferr",   n_ferr - f0, 0);

    // framing error then long break, then a good frame
    r0 = n_req; f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    tick(40);
    chk("t4_in_break",  busy, 1);
    chk("t4_ferr",      n_ferr - f0, 1);
    chk("t4_no_req",    n_req - r0, 0);
    rx = 1'b1;
    tick(5);
    chk("t4_idle",      busy, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(30);
    chk("t4_req_count", n_req - r0, 1);
    chk("t4_ferr_once", n_ferr - f0, 1);

    // overrun with ack held low
    r0 = n_req; o0 = n_ovr;
    ack_en = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    chk("t5_ovr",       n_ovr - o0, 1);
    chk("t5_req_held",  async_req, 1);
    chk("t5_d_held",    async_d, 8'h11);
    chk("t5_req_count", n_req - r0, 1);
    ack_en = 1'b1;
    tick(30);
    chk("t5_req_low",   async_req, 0);
    chk("t5_queue",     exp_q.size(), 0);

    // reset mid-DATA
    rx = 1'b0;
    tick(CPB);
    b = 8'h77;
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(CPB);
    end
    reset = 1'b1;
    tick(1);
    chk_all_zero("t6a_reset");
    reset = 1'b0;
    rx    = 1'b1;
    tick(20);
    r0 = n_req;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    tick(30);
    chk("t6a_req_count", n_req - r0, 1);

    // reset during H_REQ
    ack_en = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(3);
    chk("t6b_in_req", async_req, 1);
    reset = 1'b1;
    tick(1);
    chk_all_zero("t6b_reset");
    reset  = 1'b0;
    ack_en = 1'b1;
    tick(5);
    r0 = n_req;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    tick(30);
    chk("t6b_req_count", n_req - r0, 1);

    // random words, random gaps and responder timing
    r0 = n_req; f0 = n_ferr; o0 = n_ovr;
    for (int i = 0; i < 10; i++) begin
      b      = 8'($urandom_range(0, 255));
      up_dly = $urandom_range(1, 6);
      dn_dly = $urandom_range(1, 6);
      tick($urandom_range(0, 12));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    tick(40);
    chk("rnd_req_count", n_req - r0, 10);
    chk("rnd_ferr",      n_ferr - f0, 0);
    chk("rnd_ovr",       n_ovr - o0, 0);
    chk("rnd_queue",     exp_q.size(), 0);
    chk("end_req_low",   async_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
